// File: rtl/gshare_pattern_table.sv
// Gshare pattern history table: 2-bit saturating counters indexed by PC ^ GHR.
// A FIFO holds the index of each in-flight branch so that resolution trains the predicting counter.
module gshare_pattern_table #(
   parameter int unsigned BPRED_WIDTH = 32,
   parameter int unsigned INDEX_WIDTH = 10,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                             i_Clk,
   input  logic                             i_Reset,
   input  logic                             i_DEC_Is_Branch,
   input  logic [31:0]                      i_DEC_PC,
   input  logic [BPRED_WIDTH-1:0]           i_Global_History,
   input  logic                             i_ALU_Branch_Valid,
   input  logic                             i_ALU_Branch_Outcome,
   input  logic                             i_Flush,
   output logic                             o_Prediction,
   output logic                             o_Stall,
   output logic [$clog2(FIFO_DEPTH):0]      o_Inflight_Count,
   output logic                             o_Underflow
);

   localparam int unsigned TableSize = 1 << INDEX_WIDTH;
   localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW      = PtrW + 1;

   logic [1:0]             pht_q  [TableSize];
   logic [INDEX_WIDTH-1:0] fifo_q [FIFO_DEPTH];

   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]        count_q, count_d;
   logic                   underflow_q, underflow_d;

   logic [INDEX_WIDTH-1:0] dec_idx;
   logic [INDEX_WIDTH-1:0] head_idx;
   logic [1:0]             head_cnt;
   logic [1:0]             trained_cnt;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic                   unused_bits;

   // Only the index-forming slices of PC and history are consumed.
   assign unused_bits = ^{i_DEC_PC, i_Global_History};

   assign dec_idx  = i_DEC_PC[INDEX_WIDTH+1:2] ^ i_Global_History[INDEX_WIDTH-1:0];
   assign head_idx = fifo_q[rd_ptr_q];
   assign head_cnt = pht_q[head_idx];

   assign full  = (count_q == CntW'(FIFO_DEPTH));
   assign empty = (count_q == '0);

   // A same-cycle resolve frees a slot, so a full FIFO still accepts the push.
   assign o_Stall = full & i_DEC_Is_Branch & ~i_ALU_Branch_Valid;
   assign push    = i_DEC_Is_Branch & ~o_Stall & ~i_Flush;
   assign pop     = i_ALU_Branch_Valid & ~empty;

   assign o_Prediction     = pht_q[dec_idx][1];
   assign o_Inflight_Count = count_q;
   assign o_Underflow      = underflow_q;

   always_comb begin
      trained_cnt = head_cnt;
      if (i_ALU_Branch_Outcome) begin
         if (head_cnt != 2'b11) trained_cnt = head_cnt + 2'b01;
      end else begin
         if (head_cnt != 2'b00) trained_cnt = head_cnt - 2'b01;
      end
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      underflow_d = underflow_q | (i_ALU_Branch_Valid & empty);
      if (i_Flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + PtrW'(push);
         rd_ptr_d = rd_ptr_q + PtrW'(pop);
         count_d  = count_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         underflow_q <= underflow_d;
      end
   end

   // Flush still trains: the resolving branch is older than anything squashed.
   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         for (int i = 0; i < TableSize; i++) pht_q[i] <= 2'b01;
      end else if (pop) begin
         pht_q[head_idx] <= trained_cnt;
      end
   end

   // Entry storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge i_Clk) begin
      if (push) fifo_q[wr_ptr_q] <= dec_idx;
   end

endmodule

// File: tb/tb_gshare_pattern_table.sv
// Directed bench for gshare_pattern_table with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_gshare_pattern_table;

   logic        clk;
   logic        rst_n;
   logic        is_branch;
   logic [31:0] pc;
   logic [31:0] ghr;
   logic        br_valid;
   logic        br_taken;
   logic        flush;
   logic        pred;
   logic        stall;
   logic [2:0]  count;
   logic        underflow;

   int tests = 0;
   int fails = 0;

   gshare_pattern_table dut (
      .i_Clk                (clk),
      .i_Reset              (rst_n),
      .i_DEC_Is_Branch      (is_branch),
      .i_DEC_PC             (pc),
      .i_Global_History     (ghr),
      .i_ALU_Branch_Valid   (br_valid),
      .i_ALU_Branch_Outcome (br_taken),
      .i_Flush              (flush),
      .o_Prediction         (pred),
      .o_Stall              (stall),
      .o_Inflight_Count     (count),
      .o_Underflow          (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and leave the inputs idle.
   task automatic step();
      @(posedge clk);
      #1;
      is_branch = 1'b0;
      br_valid  = 1'b0;
      br_taken  = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic peek(input string tag, input logic [31:0] p, input logic [31:0] g,
                       input logic exp);
      pc  = p;
      ghr = g;
      #1;
      chk(tag, 32'(pred), 32'(exp));
   endtask

   task automatic push_br(input logic [31:0] p);
      is_branch = 1'b1;
      pc        = p;
      ghr       = 32'h0;
      step();
   endtask

   task automatic resolve(input logic taken);
      br_valid = 1'b1;
      br_taken = taken;
      step();
   endtask

   initial begin
      rst_n     = 1'b0;
      is_branch = 1'b0;
      pc        = 32'h0;
      ghr       = 32'h0;
      br_valid  = 1'b0;
      br_taken  = 1'b0;
      flush     = 1'b0;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      peek("rst_pred_a", 32'h0000_0040, 32'h0, 1'b0);
      peek("rst_pred_b", 32'h0000_1234, 32'h0000_0abc, 1'b0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);

      // Train idx 0x010 toward taken: 01 -> 10 -> 11 -> 11, then back to 10
      push_br(32'h0000_0040);
      chk("push_count", 32'(count), 32'd1);
      resolve(1'b1);
      chk("pop_count", 32'(count), 32'd0);
      peek("train1_pred", 32'h0000_0040, 32'h0, 1'b1);
      push_br(32'h0000_0040);
      resolve(1'b1);
      peek("train2_pred", 32'h0000_0040, 32'h0, 1'b1);
      push_br(32'h0000_0040);
      resolve(1'b1);
      peek("train3_pred", 32'h0000_0040, 32'h0, 1'b1);
      push_br(32'h0000_0040);
      resolve(1'b0);
      peek("sat_hi_pred", 32'h0000_0040, 32'h0, 1'b1);

      // Aliasing: PC 0 with GHR 0x10 hits the same counter (now 10)
      peek("alias_pred", 32'h0000_0000, 32'h10, 1'b1);
      peek("alias_other", 32'h0000_0040, 32'h1, 1'b0);
      is_branch = 1'b1;
      pc        = 32'h0000_0000;
      ghr       = 32'h10;
      step();
      resolve(1'b0);
      peek("alias_back", 32'h0000_0040, 32'h0, 1'b0);

      // FIFO full: indices 0x040, 0x080, 0x0c0, 0x100, then 0x140
      for (int i = 1; i <= 4; i++) begin
         is_branch = 1'b1;
         pc        = 32'(i) << 8;
         ghr       = 32'h0;
         #1;
         chk("fill_stall", 32'(stall), 32'd0);
         step();
      end
      chk("full_count", 32'(count), 32'd4);
      is_branch = 1'b1;
      pc        = 32'h0000_0500;
      #1;
      chk("full_stall", 32'(stall), 32'd1);
      step();
      chk("stalled_count", 32'(count), 32'd4);
      is_branch = 1'b1;
      pc        = 32'h0000_0500;
      br_valid  = 1'b1;
      br_taken  = 1'b1;
      #1;
      chk("full_pop_stall", 32'(stall), 32'd0);
      step();
      chk("full_pop_count", 32'(count), 32'd4);
      peek("head1_pred", 32'h0000_0100, 32'h0, 1'b1);
      peek("head2_untrained", 32'h0000_0200, 32'h0, 1'b0);
      resolve(1'b1);
      peek("head2_pred", 32'h0000_0200, 32'h0, 1'b1);
      peek("head3_untrained", 32'h0000_0300, 32'h0, 1'b0);
      resolve(1'b1);
      resolve(1'b0);
      resolve(1'b1);
      chk("drain_count", 32'(count), 32'd0);
      peek("head3_pred", 32'h0000_0300, 32'h0, 1'b1);
      peek("head4_pred", 32'h0000_0400, 32'h0, 1'b0);
      peek("head5_pred", 32'h0000_0500, 32'h0, 1'b1);

      // Flush with simultaneous resolve and DEC push
      push_br(32'h0000_0600);
      push_br(32'h0000_0700);
      push_br(32'h0000_0800);
      chk("pre_flush_count", 32'(count), 32'd3);
      is_branch = 1'b1;
      pc        = 32'h0000_0900;
      br_valid  = 1'b1;
      br_taken  = 1'b1;
      flush     = 1'b1;
      step();
      chk("flush_count", 32'(count), 32'd0);
      peek("flush_head_pred", 32'h0000_0600, 32'h0, 1'b1);
      peek("flush_second_pred", 32'h0000_0700, 32'h0, 1'b0);
      chk("flush_no_underflow", 32'(underflow), 32'd0);
      resolve(1'b1);
      chk("underflow_set", 32'(underflow), 32'd1);
      chk("underflow_count", 32'(count), 32'd0);
      peek("underflow_no_train", 32'h0000_0700, 32'h0, 1'b0);
      peek("underflow_no_push", 32'h0000_0900, 32'h0, 1'b0);
      step();
      chk("underflow_sticky", 32'(underflow), 32'd1);

      // Asynchronous reset mid-flight
      push_br(32'h0000_0100);
      push_br(32'h0000_0200);
      chk("midrst_pre_count", 32'(count), 32'd2);
      peek("midrst_pre_pred", 32'h0000_0300, 32'h0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_underflow", 32'(underflow), 32'd0);
      peek("midrst_pred_a", 32'h0000_0300, 32'h0, 1'b0);
      peek("midrst_pred_b", 32'h0000_0600, 32'h0, 1'b0);
      rst_n = 1'b1;
      step();
      chk("post_rst_count", 32'(count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gshare_pattern_table.md
# gshare_pattern_table

Pattern history table for the gshare branch predictor. It is the consumer of the global history register's `o_Global_History`. The DEC stage indexes it with PC XOR history and gets the prediction bit that feeds the GHR's `i_Prediction`. The block holds the table index of each in-flight branch in a small FIFO, so the EX-stage resolution trains the same 2-bit counter that produced the prediction.

## Interface

Parameters:
- `BPRED_WIDTH`, default 32: width of the global history input.
- `INDEX_WIDTH`, default 10: table has 2^INDEX_WIDTH 2-bit counters.
- `FIFO_DEPTH`, default 4: maximum number of in-flight unresolved branches. Must be a power of two.

Ports:
- `i_Clk` in 1: clock. All state updates on the rising edge.
- `i_Reset` in 1: reset, asynchronous, active-low.
- `i_DEC_Is_Branch` in 1: the instruction in DEC is a conditional branch.
- `i_DEC_PC` in 32: PC of the DEC instruction.
- `i_Global_History` in BPRED_WIDTH: current GHR value.
- `i_ALU_Branch_Valid` in 1: a branch is resolving in EX this cycle.
- `i_ALU_Branch_Outcome` in 1: 1 = taken, 0 = not taken.
- `i_Flush` in 1: pipeline flush after a mispredict; squashes younger in-flight branches.
- `o_Prediction` out 1: combinational prediction, the MSB of the indexed counter.
- `o_Stall` out 1: DEC branch cannot be accepted this cycle.
- `o_Inflight_Count` out log2(FIFO_DEPTH)+1: number of FIFO entries.
- `o_Underflow` out 1: sticky flag; a resolve arrived with the FIFO empty.

## Operation

- **Index:** `idx = i_DEC_PC[INDEX_WIDTH+1:2] ^ i_Global_History[INDEX_WIDTH-1:0]`.
- **Prediction:** `o_Prediction = table[idx][1]`.
  - Combinational, valid every cycle.
  - Consumers sample it only when `i_DEC_Is_Branch = 1`.
- **Push:** when `i_DEC_Is_Branch` is high and the branch is accepted, `idx` is written at the FIFO tail on the edge.
  - Accepted means `o_Stall = 0` and `i_Flush = 0`.
- **Pop/train:** when `i_ALU_Branch_Valid` is high and the FIFO is non-empty:
  - Pop the head index `h`.
  - Taken: `table[h]` increments, saturating at 2'b11.
  - Not taken: `table[h]` decrements, saturating at 2'b00.
- **Underflow:** `i_ALU_Branch_Valid` with an empty FIFO changes no counter, leaves the FIFO unchanged, and sets `o_Underflow`. It stays set until reset.
- **Stall:** `o_Stall = full & i_DEC_Is_Branch & ~i_ALU_Branch_Valid`.
  - When the FIFO is full and a pop occurs in the same cycle, the push is accepted. The count stays at FIFO_DEPTH.
- **Simultaneous push and pop:** both are performed and the count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- **Flush:**
  - On an edge with `i_Flush = 1`, the FIFO empties: both pointers go to 0 and the count goes to 0.
  - A pop in the same cycle still trains its counter, because the resolving branch is the older one.
  - A push in the same cycle is discarded.
  - Counters are never cleared by flush.
- **Read/write collision:** if the trained entry equals the DEC index in the same cycle, `o_Prediction` shows the pre-update value. There is no bypass.

## Timing

- **Reset** (asynchronous, `i_Reset = 0`):
  - Every counter = 2'b01 (weakly not taken), so `o_Prediction = 0`.
  - FIFO pointers = 0, `o_Inflight_Count = 0`, `o_Underflow = 0`, `o_Stall = 0`.
  - Reset in mid-operation discards all in-flight entries immediately.
- **Prediction latency:** 0 cycles after `i_DEC_PC` and `i_Global_History` settle.
- **Training latency:** the counter update becomes visible on `o_Prediction` one cycle after the resolving edge.
- **Push latency:** `o_Inflight_Count` reflects a push or pop one cycle after the edge.
- **Stall:** `o_Stall` is combinational in the same cycle as the request. The DEC stage holds the branch and re-presents it next cycle; the re-presented branch is indexed with the then-current GHR.
- **Counter arithmetic:** 2-bit unsigned with saturation. No wrap from 3 to 0 or from 0 to 3.

## Test plan

- **Reset:** hold `i_Reset = 0` for 2 cycles, then release. For any PC/GHR, `o_Prediction = 0`, `o_Inflight_Count = 0`, `o_Underflow = 0`, `o_Stall = 0`.
- **Train to taken:**
  - PC = 0x0000_0040, GHR = 0. Push; resolve taken. Repeat push/resolve taken once more.
  - Counter goes 01→10→11. `o_Prediction` reads 1 after the first resolve and stays 1.
  - A third taken resolve leaves the counter at 11 (saturation).
- **Index aliasing:**
  - PC = 0x0000_0040 with GHR = 0x0 and PC = 0x0000_0000 with GHR = 0x10 both give idx = 0x010.
  - After training one to 11, the other predicts 1.
  - PC = 0x0000_0040 with GHR = 0x1 gives idx = 0x011 and still predicts 0.
- **FIFO full:**
  - Push 4 branches with no resolve: count = 4.
  - 5th DEC branch alone: `o_Stall = 1` and count stays 4.
  - 5th DEC branch with a resolve in the same cycle: `o_Stall = 0` and count stays 4. Resolves pop the heads in order, training the first-pushed index first.
- **Flush:**
  - Push 3 branches. Next cycle assert `i_ALU_Branch_Valid` (taken), `i_Flush`, and `i_DEC_Is_Branch` together.
  - The head counter increments, the count becomes 0, and the DEC push is discarded.
  - A following resolve sets `o_Underflow = 1` and changes no counter.
- **Reset mid-flight:** with count = 2, pulse `i_Reset = 0` between edges. The count is 0 asynchronously and all counters read 01.
